// File: rtl/adc_scan_ctrl.sv
// Timer-driven multi-channel ADC scan sequencer producing a tagged sample stream.
// Build macro ADC_SCAN_AVG_EN: average 2^AVG_LOG2 back-to-back conversions per channel.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a sample-timer tick with a non-zero mask
// S_SETTLE   | chsel driven, holding SETTLE_CYC cycles before conversion
// S_SOC      | one-cycle start-of-conversion pulse
// S_WAIT_EOC | waiting for eoc_in, bounded by TIMEOUT_CYC
// S_CAPTURE  | one-cycle sample strobe
// S_NEXT     | pick next enabled channel or close the frame
module adc_scan_ctrl #(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 4,
    parameter int CH_SEL_W    = 5,
    parameter int CH_BASE     = 4,
    parameter int PERIOD_W    = 16,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255,
`ifdef ADC_SCAN_AVG_EN
    parameter int AVG_LOG2    = 2,
`endif
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [NUM_CH-1:0]   ch_mask_in,
    input  logic                clr_err_in,
    input  logic                eoc_in,
    input  logic [DATA_W-1:0]   adc_dout_in,
    output logic [CH_SEL_W-1:0] chsel_out,
    output logic                soc_out,
    output logic [DATA_W-1:0]   sample_out,
    output logic [CH_W-1:0]     sample_ch_out,
    output logic                sample_valid_out,
    output logic                frame_done_out,
    output logic                busy_out,
    output logic                overrun_out,
    output logic                timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SOC, S_WAIT_EOC, S_CAPTURE, S_NEXT
    } state_t;

    localparam int DLY_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
    localparam logic [DLY_W-1:0] SETTLE_LD = DLY_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [DLY_W-1:0] TMO_LD    = DLY_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam state_t ENTER_ST = (SETTLE_CYC > 0) ? S_SETTLE : S_SOC;

    state_t                state_q, state_nxt;
    logic [PERIOD_W-1:0]   tmr_q;
    logic [NUM_CH-1:0]     mask_q;
    logic [CH_W-1:0]       idx_q, first_idx, next_idx, new_idx;
    logic                  first_hit, next_hit;
    logic [DLY_W-1:0]      dly_q;
    logic [CH_SEL_W-1:0]   chsel_q;
    logic [DATA_W-1:0]     sample_q, cap_data;
    logic                  ovr_q, tmo_q;
    logic                  tick, start, start_ch, eoc_evt, tmo_evt, last_conv;

    assign tick     = en_in && (tmr_q == period_in);
    assign start    = (state_q == S_IDLE) && tick && first_hit;
    assign start_ch = start || ((state_q == S_NEXT) && next_hit);
    assign new_idx  = start ? first_idx : next_idx;
    assign eoc_evt  = (state_q == S_WAIT_EOC) && eoc_in;
    assign tmo_evt  = (state_q == S_WAIT_EOC) && !eoc_in && (dly_q == '0);

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_in[i]) begin
                first_hit = 1'b1;
                first_idx = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_hit = 1'b1;
                next_idx = CH_W'(i);
            end
        end
    end

`ifdef ADC_SCAN_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    logic [AVG_LOG2-1:0] conv_q;
    logic [ACC_W-1:0]    acc_q, acc_sum;

    assign acc_sum   = acc_q + ACC_W'(adc_dout_in);
    assign last_conv = &conv_q;
    assign cap_data  = acc_sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            conv_q <= '0;
            acc_q  <= '0;
        end else if (start_ch) begin
            conv_q <= '0;
            acc_q  <= '0;
        end else if (eoc_evt && !last_conv) begin
            conv_q <= conv_q + 1'b1;
            acc_q  <= acc_sum;
        end
    end
`else
    assign last_conv = 1'b1;
    assign cap_data  = adc_dout_in;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:     if (start) state_nxt = ENTER_ST;
            S_SETTLE:   if (dly_q == '0) state_nxt = S_SOC;
            S_SOC:      state_nxt = S_WAIT_EOC;
            S_WAIT_EOC: begin
                if (eoc_in)             state_nxt = last_conv ? S_CAPTURE : S_SOC;
                else if (dly_q == '0)   state_nxt = S_NEXT;
            end
            S_CAPTURE:  state_nxt = S_NEXT;
            S_NEXT:     state_nxt = next_hit ? ENTER_ST : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        soc_out          = 1'b0;
        sample_valid_out = 1'b0;
        frame_done_out   = 1'b0;
        busy_out         = 1'b1;
        case (state_q)
            S_IDLE:    busy_out         = 1'b0;
            S_SOC:     soc_out          = 1'b1;
            S_CAPTURE: sample_valid_out = 1'b1;
            S_NEXT:    frame_done_out   = !next_hit;
            default:   ;
        endcase
    end

    // One down-counter serves both settle and EOC timeout; SOC always precedes WAIT_EOC.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmr_q    <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            dly_q    <= '0;
            chsel_q  <= CH_SEL_W'(CH_BASE);
            sample_q <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            tmr_q <= (!en_in || tick) ? '0 : tmr_q + 1'b1;
            if (start) mask_q <= ch_mask_in;
            if (start_ch) begin
                idx_q   <= new_idx;
                chsel_q <= CH_SEL_W'(CH_BASE) + CH_SEL_W'(new_idx);
                dly_q   <= SETTLE_LD;
            end else if (state_q == S_SOC) begin
                dly_q <= TMO_LD;
            end else if (dly_q != '0) begin
                dly_q <= dly_q - 1'b1;
            end
            if (eoc_evt && last_conv) sample_q <= cap_data;
            if (tick && (state_q != S_IDLE)) ovr_q <= 1'b1;
            else if (clr_err_in)             ovr_q <= 1'b0;
            if (tmo_evt)         tmo_q <= 1'b1;
            else if (clr_err_in) tmo_q <= 1'b0;
        end
    end

    assign chsel_out     = chsel_q;
    assign sample_out    = sample_q;
    assign sample_ch_out = idx_q;
    assign overrun_out   = ovr_q;
    assign timeout_out   = tmo_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: behavioural ADC responder, strobe monitor, per-feature tasks.
module tb_adc_scan_ctrl;
    localparam int CH_BASE = 4;
`ifdef ADC_SCAN_AVG_EN
    localparam int CONV = 4;
`else
    localparam int CONV = 1;
`endif

    logic        clk_in = 1'b0, rst_in = 1'b0, en_in = 1'b0, clr_err_in = 1'b0, eoc_in = 1'b0;
    logic [15:0] period_in = '0;
    logic [3:0]  ch_mask_in = '0;
    logic [11:0] adc_dout_in = '0;
    logic [4:0]  chsel_out;
    logic        soc_out, sample_valid_out, frame_done_out, busy_out, overrun_out, timeout_out;
    logic [11:0] sample_out;
    logic [1:0]  sample_ch_out;

    int n_pass = 0, n_total = 0;
    int cyc = 0, busy_cnt = 0, lat_err = 0;
    bit chk_lat = 1'b0;
    int got_smp[$], got_chsel[$], soc_times[$], fd_times[$];
    int eoc_lat = 5, never_ch = -1, eoc_cnt = 0, soc_ch = 0, seq_val = 0;
    bit use_seq = 1'b0;

    adc_scan_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .period_in(period_in),
        .ch_mask_in(ch_mask_in), .clr_err_in(clr_err_in), .eoc_in(eoc_in),
        .adc_dout_in(adc_dout_in), .chsel_out(chsel_out), .soc_out(soc_out),
        .sample_out(sample_out), .sample_ch_out(sample_ch_out),
        .sample_valid_out(sample_valid_out), .frame_done_out(frame_done_out),
        .busy_out(busy_out), .overrun_out(overrun_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // ADC model: answers each SOC after eoc_lat cycles with 0x100 + scan index.
    always @(negedge clk_in) begin
        #1;
        eoc_in = 1'b0;
        if (!rst_in) eoc_cnt = 0;
        else begin
            if (eoc_cnt > 0) begin
                eoc_cnt--;
                if (eoc_cnt == 0) begin
                    eoc_in = 1'b1;
                    adc_dout_in = use_seq ? 12'(seq_val) : 12'(256 + soc_ch);
                    seq_val++;
                end
            end
            if (soc_out && ((int'(chsel_out) - CH_BASE) != never_ch)) begin
                eoc_cnt = eoc_lat;
                soc_ch  = int'(chsel_out) - CH_BASE;
            end
        end
    end

    always @(negedge clk_in) begin
        cyc++;
        if (sample_valid_out) got_smp.push_back(int'(sample_ch_out) * 4096 + int'(sample_out));
        if (soc_out) begin
            got_chsel.push_back(int'(chsel_out));
            soc_times.push_back(cyc);
        end
        if (frame_done_out) fd_times.push_back(cyc);
        if (busy_out) busy_cnt++;
        if (chk_lat && sample_valid_out && (eoc_in !== 1'b1)) lat_err++;
`ifndef ADC_SCAN_AVG_EN
        if (chk_lat && (eoc_in === 1'b1) && !sample_valid_out) lat_err++;
`endif
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
        #2;
    endtask

    task automatic clear_mon();
        got_smp.delete(); got_chsel.delete(); soc_times.delete(); fd_times.delete();
        busy_cnt = 0; lat_err = 0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        wait_cyc(2);
        while (busy_out && c < 3000) begin wait_cyc(1); c++; end
        n_total++;
        if (busy_out !== 1'b0) $display("FAIL %s idle_wait: busy_out=%b after %0d cycles, required 0", name, busy_out, c);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        wait_cyc(2);
        n_total++;
        if ({soc_out, sample_valid_out, frame_done_out, busy_out, overrun_out, timeout_out} !== 6'b0)
            $display("FAIL reset_strobes: got %b required 000000",
                     {soc_out, sample_valid_out, frame_done_out, busy_out, overrun_out, timeout_out});
        else n_pass++;
        n_total++;
        if (sample_out !== 12'h0 || sample_ch_out !== 2'd0)
            $display("FAIL reset_sample: got %h/%0d required 0/0", sample_out, sample_ch_out);
        else n_pass++;
        n_total++;
        if (chsel_out !== 5'(CH_BASE)) $display("FAIL reset_chsel: got %0d required %0d", chsel_out, CH_BASE);
        else n_pass++;
        rst_in = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_scan(input int iters);
        for (int it = 0; it < iters; it++) begin
            int p, lat, m1, m2, c, r, budget, fmax, hi;
            int exp_smp[$];
            int exp_ch[$];
            int masks[3];
            if (it == 0) begin
                m1 = 4'b1011; m2 = 4'b1011; lat = 5;
            end else begin
                m1 = $urandom_range(1, 15); m2 = $urandom_range(1, 15); lat = $urandom_range(1, 8);
            end
            fmax = 4 * (4 + CONV * (lat + 1)) + 1;
            if (it == 0) p = (fmax + 8 < 99) ? 99 : fmax + 20;
            else p = $urandom_range(fmax + 8, fmax + 90);
            masks[0] = m1; masks[1] = m2; masks[2] = m2;
            hi = 0;
            foreach (masks[f])
                for (int i = 0; i < 4; i++)
                    if (masks[f][i]) begin
                        exp_smp.push_back(i * 4096 + 256 + i);
                        exp_ch.push_back(CH_BASE + i);
                        hi = i;
                    end
            ch_mask_in = 4'(m1); period_in = 16'(p); eoc_lat = lat;
            clear_mon();
            chk_lat = 1'b1;
            en_in = 1'b1;
            c = 0;
            while (!busy_out && c < p + 5) begin wait_cyc(1); c++; end
            n_total++;
            if (busy_out !== 1'b1 || c != p + 1)
                $display("FAIL scan_start it%0d: busy=%b after %0d cycles, required 1 after %0d", it, busy_out, c, p + 1);
            else n_pass++;
            r = $urandom_range(0, 10);
            wait_cyc(r); c += r;
            ch_mask_in = 4'(m2);
            budget = 3 * (p + 1) + fmax + 4;
            if (c < budget) wait_cyc(budget - c);
            en_in = 1'b0;
            wait_idle("scan");
            chk_lat = 1'b0;
            n_total++;
            if (got_smp.size() != exp_smp.size())
                $display("FAIL scan_count it%0d: got %0d strobes required %0d", it, got_smp.size(), exp_smp.size());
            else n_pass++;
            foreach (exp_smp[k]) begin
                n_total++;
                if (k >= got_smp.size() || got_smp[k] != exp_smp[k])
                    $display("FAIL scan_sample it%0d[%0d]: got %h required %h", it, k,
                             (k < got_smp.size()) ? got_smp[k] : -1, exp_smp[k]);
                else n_pass++;
            end
            n_total++;
            if (got_chsel.size() != exp_ch.size() * CONV)
                $display("FAIL scan_soc_count it%0d: got %0d required %0d", it, got_chsel.size(), exp_ch.size() * CONV);
            else n_pass++;
            foreach (exp_ch[k]) begin
                n_total++;
                if (k * CONV >= got_chsel.size() || got_chsel[k * CONV] != exp_ch[k])
                    $display("FAIL scan_chsel it%0d[%0d]: got %0d required %0d", it, k,
                             (k * CONV < got_chsel.size()) ? got_chsel[k * CONV] : -1, exp_ch[k]);
                else n_pass++;
            end
            n_total++;
            if (fd_times.size() != 3) $display("FAIL scan_frames it%0d: got %0d required 3", it, fd_times.size());
            else n_pass++;
            n_total++;
            if (fd_times.size() == 3 && fd_times[2] - fd_times[1] != p + 1)
                $display("FAIL scan_frame_period it%0d: got %0d required %0d", it, fd_times[2] - fd_times[1], p + 1);
            else n_pass++;
            n_total++;
            if (lat_err != 0) $display("FAIL scan_latency it%0d: got %0d bad strobes required 0", it, lat_err);
            else n_pass++;
            n_total++;
            if (overrun_out !== 1'b0 || timeout_out !== 1'b0)
                $display("FAIL scan_errors it%0d: got ovr=%b tmo=%b required 0/0", it, overrun_out, timeout_out);
            else n_pass++;
            n_total++;
            if (chsel_out !== 5'(CH_BASE + hi))
                $display("FAIL scan_chsel_hold it%0d: got %0d required %0d", it, chsel_out, CH_BASE + hi);
            else n_pass++;
        end
    endtask

    task automatic test_mask_zero();
        ch_mask_in = 4'b0000; period_in = 16'd4;
        clear_mon();
        en_in = 1'b1;
        wait_cyc(40);
        en_in = 1'b0;
        n_total++;
        if (got_chsel.size() != 0 || got_smp.size() != 0 || fd_times.size() != 0 || busy_cnt != 0)
            $display("FAIL mask_zero: got soc=%0d smp=%0d fd=%0d busy=%0d required all 0",
                     got_chsel.size(), got_smp.size(), fd_times.size(), busy_cnt);
        else n_pass++;
        wait_cyc(2);
    endtask

    task automatic test_overrun();
        ch_mask_in = 4'b0001; period_in = 16'd9; eoc_lat = 20;
        clr_err_in = 1'b1;
        en_in = 1'b1;
        wait_cyc(19);
        n_total++;
        if (overrun_out !== 1'b0) $display("FAIL overrun_before: got %b required 0", overrun_out);
        else n_pass++;
        wait_cyc(1);
        n_total++;
        if (overrun_out !== 1'b1) $display("FAIL overrun_set_wins: got %b required 1", overrun_out);
        else n_pass++;
        wait_cyc(1);
        n_total++;
        if (overrun_out !== 1'b0) $display("FAIL overrun_clear_held: got %b required 0", overrun_out);
        else n_pass++;
        clr_err_in = 1'b0;
        wait_cyc(9);
        n_total++;
        if (overrun_out !== 1'b1) $display("FAIL overrun_reset: got %b required 1", overrun_out);
        else n_pass++;
        en_in = 1'b0;
        wait_idle("overrun");
        clr_err_in = 1'b1;
        wait_cyc(1);
        clr_err_in = 1'b0;
        n_total++;
        if (overrun_out !== 1'b0) $display("FAIL overrun_clr: got %b required 0", overrun_out);
        else n_pass++;
        eoc_lat = 5;
    endtask

    task automatic test_timeout();
        int c;
        ch_mask_in = 4'b0011; period_in = 16'd399; eoc_lat = 5; never_ch = 0;
        clear_mon();
        en_in = 1'b1;
        c = 0;
        while (!soc_out && c < 500) begin wait_cyc(1); c++; end
        n_total++;
        if (soc_out !== 1'b1) $display("FAIL timeout_soc: got soc=%b required 1", soc_out);
        else n_pass++;
        wait_cyc(255);
        n_total++;
        if (timeout_out !== 1'b0) $display("FAIL timeout_early: got %b required 0", timeout_out);
        else n_pass++;
        wait_cyc(1);
        n_total++;
        if (timeout_out !== 1'b1 || busy_out !== 1'b1)
            $display("FAIL timeout_set: got tmo=%b busy=%b required 1/1", timeout_out, busy_out);
        else n_pass++;
        en_in = 1'b0;
        wait_idle("timeout");
        n_total++;
        if (got_smp.size() != 1 || got_smp[0] != 4096 + 257 || fd_times.size() != 1)
            $display("FAIL timeout_skip: got %0d strobes first %h fd=%0d required 1 strobe 1101 fd=1",
                     got_smp.size(), (got_smp.size() > 0) ? got_smp[0] : -1, fd_times.size());
        else n_pass++;
        clr_err_in = 1'b1;
        wait_cyc(1);
        clr_err_in = 1'b0;
        n_total++;
        if (timeout_out !== 1'b0) $display("FAIL timeout_clr: got %b required 0", timeout_out);
        else n_pass++;
        never_ch = -1;
    endtask

    task automatic test_reset_mid();
        int c;
        ch_mask_in = 4'b0110; period_in = 16'd149; eoc_lat = 10;
        en_in = 1'b1;
        c = 0;
        while (!soc_out && c < 300) begin wait_cyc(1); c++; end
        wait_cyc(3);
        n_total++;
        if (busy_out !== 1'b1) $display("FAIL rstmid_busy: got %b required 1", busy_out);
        else n_pass++;
        rst_in = 1'b0;
        #1;
        n_total++;
        if ({soc_out, sample_valid_out, frame_done_out, busy_out, overrun_out, timeout_out} !== 6'b0 ||
            sample_out !== 12'h0 || chsel_out !== 5'(CH_BASE))
            $display("FAIL rstmid_outputs: got strobes=%b sample=%h chsel=%0d required 0/0/%0d",
                     {soc_out, sample_valid_out, frame_done_out, busy_out, overrun_out, timeout_out},
                     sample_out, chsel_out, CH_BASE);
        else n_pass++;
        wait_cyc(2);
        clear_mon();
        rst_in = 1'b1;
        wait_cyc(150 + 2 * (4 + CONV * 11) + 5);
        en_in = 1'b0;
        wait_idle("rstmid");
        n_total++;
        if (got_smp.size() != 2 || got_smp[0] != 4096 + 257 || got_smp[1] != 8192 + 258)
            $display("FAIL rstmid_restart: got %0d strobes first %h required 2 strobes 1101,2102",
                     got_smp.size(), (got_smp.size() > 0) ? got_smp[0] : -1);
        else n_pass++;
        n_total++;
        if (got_chsel.size() == 0 || got_chsel[0] != CH_BASE + 1)
            $display("FAIL rstmid_first_chsel: got %0d required %0d",
                     (got_chsel.size() > 0) ? got_chsel[0] : -1, CH_BASE + 1);
        else n_pass++;
    endtask

`ifdef ADC_SCAN_AVG_EN
    task automatic test_avg();
        ch_mask_in = 4'b0001; period_in = 16'd99; eoc_lat = 3;
        use_seq = 1'b1; seq_val = 10;
        clear_mon();
        en_in = 1'b1;
        wait_cyc(140);
        en_in = 1'b0;
        wait_idle("avg");
        n_total++;
        if (got_smp.size() != 1 || got_smp[0] != 11)
            $display("FAIL avg_sample: got %0d strobes first %0d required 1 strobe 11",
                     got_smp.size(), (got_smp.size() > 0) ? got_smp[0] : -1);
        else n_pass++;
        n_total++;
        if (soc_times.size() != 4) $display("FAIL avg_soc_count: got %0d required 4", soc_times.size());
        else n_pass++;
        for (int k = 1; k < soc_times.size(); k++) begin
            n_total++;
            if (soc_times[k] - soc_times[k - 1] != eoc_lat + 1)
                $display("FAIL avg_no_resettle[%0d]: got spacing %0d required %0d", k,
                         soc_times[k] - soc_times[k - 1], eoc_lat + 1);
            else n_pass++;
        end
        use_seq = 1'b0;
    endtask
`endif

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached with %0d of %0d comparisons done", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan(5);
        test_mask_zero();
        test_overrun();
        test_timeout();
        test_reset_mid();
`ifdef ADC_SCAN_AVG_EN
        test_avg();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
